// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Byte-stream instruction sequencer for an external 8-bit
//                combinational ALU. Holds a 4 x 8-bit register file, presents
//                registered operands/opcode to the ALU, writes results back
//                and emits register contents over a valid/ready output port.
//
//  Instruction byte: [7:5] op, [4:3] rd, [2:1] rs, [0] imm
//    op 000..100 : ALU ADD/SUB/AND/OR/NOT (imm=1 -> operand B is next byte)
//    op 101      : LDI  R[rd] = next byte
//    op 110      : HALT (only reset exits)
//    op 111      : OUT  R[rs]
//
//  Ports:
//    clk, rst_n                  clock / asynchronous active-low reset
//    instr_data/valid/ready      instruction byte stream (valid/ready)
//    alu_a, alu_b, alu_opcode    registered ALU operands and opcode
//    alu_result                  combinational ALU result
//    wb_valid/addr/data          one-cycle write-back report
//    out_data/valid/ready        OUT instruction data port (valid/ready)
//    halted                      sequencer is in HALT
//    flag_z, flag_n              zero/negative flags (SEQ_FLAGS_EN only)
//
//  Optional feature macro: SEQ_FLAGS_EN
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter logic [7:0] REG_INIT      = 8'h00,
    parameter bit         OUT_HOLD_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] instr_data,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_result,
    output logic       wb_valid,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef SEQ_FLAGS_EN
    output logic       flag_z,
    output logic       flag_n,
`endif
    output logic       halted
);

    localparam logic [2:0] c_OP_LDI  = 3'b101;
    localparam logic [2:0] c_OP_HALT = 3'b110;
    localparam logic [2:0] c_OP_OUT  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMM   = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_OUTW  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_regs [4];
    logic [2:0] r_op;
    logic [1:0] r_rd;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic [1:0] r_wb_addr;
    logic [7:0] r_wb_data;
    logic [7:0] r_out_data;
    logic       r_out_valid;

    // Fields of the incoming byte (decoded only while in FETCH)
    logic [2:0] w_in_op;
    logic [1:0] w_in_rd;
    logic [1:0] w_in_rs;
    logic       w_in_imm;
    logic       w_xfer;

    assign w_in_op  = instr_data[7:5];
    assign w_in_rd  = instr_data[4:3];
    assign w_in_rs  = instr_data[2:1];
    assign w_in_imm = instr_data[0];
    assign w_xfer   = instr_valid & instr_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        wb_valid    = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (w_xfer) begin
                    if (w_in_op == c_OP_HALT)      w_next = S_HALT;
                    else if (w_in_op == c_OP_OUT)  w_next = S_OUTW;
                    else if (w_in_op == c_OP_LDI)  w_next = S_IMM;
                    else if (w_in_imm)             w_next = S_IMM;
                    else                           w_next = S_EXEC;
                end
            end
            S_IMM: begin
                instr_ready = 1'b1;
                if (w_xfer) begin
                    w_next = (r_op == c_OP_LDI) ? S_WB : S_EXEC;
                end
            end
            S_EXEC:  w_next = S_WB;
            S_WB: begin
                wb_valid = 1'b1;
                w_next   = S_FETCH;
            end
            S_OUTW: begin
                if (out_ready) w_next = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: register file, ALU operand registers, write-back, OUT port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= REG_INIT;
            r_op        <= 3'd0;
            r_rd        <= 2'd0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_op    <= 3'd0;
            r_wb_addr   <= 2'd0;
            r_wb_data   <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_xfer) begin
                        r_op <= w_in_op;
                        r_rd <= w_in_rd;
                        if (w_in_op == c_OP_OUT) begin
                            r_out_data  <= r_regs[w_in_rs];
                            r_out_valid <= 1'b1;
                        end else if (w_in_op < c_OP_LDI && !w_in_imm) begin
                            r_alu_a  <= r_regs[w_in_rd];
                            r_alu_b  <= r_regs[w_in_rs];
                            r_alu_op <= w_in_op;
                        end
                    end
                end
                S_IMM: begin
                    if (w_xfer) begin
                        if (r_op == c_OP_LDI) begin
                            r_regs[r_rd] <= instr_data;
                            r_wb_addr    <= r_rd;
                            r_wb_data    <= instr_data;
                        end else begin
                            r_alu_a  <= r_regs[r_rd];
                            r_alu_b  <= instr_data;
                            r_alu_op <= r_op;
                        end
                    end
                end
                S_EXEC: begin
                    // Result is captured unmodified; wrap happens in the ALU.
                    r_regs[r_rd] <= alu_result;
                    r_wb_addr    <= r_rd;
                    r_wb_data    <= alu_result;
                end
                S_OUTW: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_flag_z <= (alu_result == 8'h00);
            r_flag_n <= alu_result[7];
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_op;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign out_valid  = r_out_valid;
    // Optionally blank the data bus whenever no OUT transfer is offered
    assign out_data   = (OUT_HOLD_ZERO && !r_out_valid) ? 8'h00 : r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. Models the external
//                ALU, keeps a write-back scoreboard (expected addr/data
//                pushed when an instruction is driven, popped by a monitor
//                on each wb_valid) and checks directed scenarios inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       halted;
`ifdef SEQ_FLAGS_EN
    logic       flag_z;
    logic       flag_n;
`endif

    int tests  = 0;
    int failed = 0;

    logic [9:0] sb_q [$];   // {addr[1:0], data[7:0]}

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_data (instr_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef SEQ_FLAGS_EN
        .flag_z     (flag_z),
        .flag_n     (flag_n),
`endif
        .halted     (halted)
    );

    // Reference ALU
    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = ~alu_a;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-back monitor: every wb_valid pulse must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", {30'd0, wb_valid}, 32'd0);
            end else begin
                logic [9:0] e;
                e = sb_q.pop_front();
                check("wb_addr", {30'd0, wb_addr}, {30'd0, e[9:8]});
                check("wb_data", {24'd0, wb_data}, {24'd0, e[7:0]});
            end
        end
    end

    // Drive one byte and return 1 time unit after the edge that accepted it
    task automatic send(input logic [7:0] b);
        int n;
        instr_data  = b;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        sb_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // OUT with out_ready already high: one-cycle out_valid carrying exp
    task automatic do_out(input logic [7:0] b, input logic [7:0] exp, input string tag);
        out_ready = 1'b1;
        send(b);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        tick(1);
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        instr_data  = 8'h00;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        rst_n       = 1'b1;
        #2;
        do_reset();

        // Reset state
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_out_valid",   {31'd0, out_valid},   32'd0);
        check("rst_wb_valid",    {31'd0, wb_valid},    32'd0);
        check("rst_halted",      {31'd0, halted},      32'd0);
        check("rst_alu_a",       {24'd0, alu_a},       32'd0);
        do_out(8'hE0, 8'h00, "out_r0_init");

        // LDI R0,5 ; LDI R1,3 ; ADD R0,R1
        sb_q.push_back({2'd0, 8'h05}); send(8'hA0); send(8'h05);
        sb_q.push_back({2'd1, 8'h03}); send(8'hA8); send(8'h03);
        sb_q.push_back({2'd0, 8'h08}); send(8'h02);
        check("add_alu_a",  {24'd0, alu_a},      32'h05);
        check("add_alu_b",  {24'd0, alu_b},      32'h03);
        check("add_opcode", {29'd0, alu_opcode}, 32'd0);
        check("add_wb_n1",  {31'd0, wb_valid},   32'd0);
        tick(1);
        check("add_wb_n2",  {31'd0, wb_valid},   32'd1);
        check("add_wb_data", {24'd0, wb_data},   32'h08);

        // SUB R0,#9 -> 0xFF (wrap)
        sb_q.push_back({2'd0, 8'hFF}); send(8'h21); send(8'h09);
        check("sub_alu_b", {24'd0, alu_b}, 32'h09);
        tick(1);
`ifdef SEQ_FLAGS_EN
        check("sub_flag_n", {31'd0, flag_n}, 32'd1);
        check("sub_flag_z", {31'd0, flag_z}, 32'd0);
`endif
        // AND R0,#0 -> 0x00
        sb_q.push_back({2'd0, 8'h00}); send(8'h41); send(8'h00);
        tick(1);
`ifdef SEQ_FLAGS_EN
        check("and_flag_z", {31'd0, flag_z}, 32'd1);
        check("and_flag_n", {31'd0, flag_n}, 32'd0);
`endif
        // NOT R1 -> 0xFC
        sb_q.push_back({2'd1, 8'hFC}); send(8'h88);
        check("not_opcode", {29'd0, alu_opcode}, 32'd4);
        tick(2);

        // OUT R1 with out_ready held low for 5 cycles
        out_ready = 1'b0;
        send(8'hE2);
        for (int i = 0; i < 5; i++) begin
            check("outw_valid", {31'd0, out_valid},   32'd1);
            check("outw_data",  {24'd0, out_data},    32'hFC);
            check("outw_ready", {31'd0, instr_ready}, 32'd0);
            tick(1);
        end
        out_ready = 1'b1;
        check("outw_xfer_valid", {31'd0, out_valid}, 32'd1);
        tick(1);
        out_ready = 1'b0;
        check("outw_done_valid", {31'd0, out_valid},   32'd0);
        check("outw_done_fetch", {31'd0, instr_ready}, 32'd1);

        // R0 should now hold 0x00 from the AND
        do_out(8'hE0, 8'h00, "out_r0_after_and");

        // HALT: no progress while bytes are offered
        send(8'hC0);
        instr_data  = 8'hA0;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("halt_halted", {31'd0, halted},      32'd1);
            check("halt_ready",  {31'd0, instr_ready}, 32'd0);
            tick(1);
        end
        instr_valid = 1'b0;
        check("halt_sb_empty", sb_q.size(), 32'd0);
        do_reset();
        check("halt_exit_halted", {31'd0, halted},      32'd0);
        check("halt_exit_ready",  {31'd0, instr_ready}, 32'd1);

        // Reset during EXEC of ADD R2,R3 aborts and restores REG_INIT
        sb_q.push_back({2'd2, 8'h11}); send(8'hB0); send(8'h11);
        sb_q.push_back({2'd3, 8'h22}); send(8'hB8); send(8'h22);
        tick(1);
        send(8'h16);            // now in EXEC
        rst_n = 1'b0;
        #1;
        check("abort_wb_valid",  {31'd0, wb_valid},  32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("abort_wb_after", {31'd0, wb_valid}, 32'd0);
        do_out(8'hE4, 8'h00, "out_r2_init");
        do_out(8'hE6, 8'h00, "out_r3_init");

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Instruction sequencer that drives the 8-bit ALU: accepts a byte-wide instruction stream over a valid/ready handshake and decodes each instruction. It holds a 4-entry x 8-bit register file, presents operands and a 3-bit opcode to the ALU, and writes the ALU result back. Register contents can be emitted on a valid/ready output port. Sits between the instruction source (ROM/host FIFO) and the combinational ALU.

Parameters:
REG_INIT, 8'h00, reset value of all four registers R0-R3
OUT_HOLD_ZERO, 1, 1 = out_data forced to 8'h00 while out_valid=0; 0 = out_data holds last value

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_data  input  8  instruction or immediate byte
instr_valid  input  1  instr_data valid
instr_ready  output  1  sequencer accepts a byte this cycle
alu_a  output  8  ALU operand A (registered)
alu_b  output  8  ALU operand B (registered)
alu_opcode  output  3  ALU opcode (registered)
alu_result  input  8  ALU combinational result
wb_valid  output  1  one-cycle pulse: register write-back occurred
wb_addr  output  2  register written
wb_data  output  8  value written
out_data  output  8  OUT instruction data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
halted  output  1  sequencer in HALT

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n (asserting rst_n=0 resets immediately, regardless of clk).
- Instruction byte: [7:5] op, [4:3] rd, [2:1] rs, [0] imm. op 000-100 = ALU ADD/SUB/AND/OR/NOT; 101 = LDI; 110 = HALT; 111 = OUT.
- Reset: state FETCH, R0-R3=REG_INIT, all outputs 0 except instr_ready=1 in FETCH (combinational from state).
- A byte transfers when instr_valid & instr_ready. instr_ready=1 only in FETCH and IMM.
- FETCH: on transfer, latch instr.
  - ALU op with imm=1, or LDI: go to IMM.
  - ALU op with imm=0: load alu_a=R[rd], alu_b=R[rs], alu_opcode=op; go to EXEC.
  - OUT: load out_data=R[rs], set out_valid=1; go to OUTW.
  - HALT: go to HALT.
- IMM: on transfer:
  - LDI: R[rd]=byte; go to WB.
  - ALU op: alu_a=R[rd], alu_b=byte, alu_opcode=op; go to EXEC.
- EXEC (1 cycle): at the clock edge, R[rd]=alu_result and wb_data=alu_result; go to WB.
- WB (1 cycle): wb_valid=1, wb_addr=rd, wb_data=written value; go to FETCH. For LDI, wb_data=immediate.
- Latency: ALU op without immediate is accepted at cycle N, EXEC at N+1, wb_valid at N+2, instr_ready at N+3. With an immediate, add one cycle per byte wait.
- NOT ignores rs and B. The imm bit still consumes one immediate byte; alu_b=byte is presented but unused.
- rd==rs is legal; operands are read before write.
- OUTW: hold out_valid and out_data stable until out_ready=1. Transfer completes on the out_valid & out_ready cycle; out_valid drops next cycle; go to FETCH. If out_ready is already 1, out_valid is high for exactly one cycle.
- HALT: halted=1, instr_ready=0, all other outputs hold. Only reset exits HALT.
- Arithmetic wraps modulo 256 (performed in ALU). The sequencer stores alu_result unmodified.
- Reset mid-operation (any state) aborts: no write-back, out_valid=0, registers return to REG_INIT.
- alu_a, alu_b and alu_opcode hold their last value outside EXEC.

Optional Feature:
Macro SEQ_FLAGS_EN.
- Defined: adds outputs flag_z (1) and flag_n (1), both reset to 0. On every EXEC write-back, flag_z=(alu_result==0) and flag_n=alu_result[7]. LDI, OUT and HALT leave flags unchanged.
- Undefined: the ports and logic are absent.

Test Plan:
- Reset: rst_n=0, then release -> instr_ready=1, out_valid=0, wb_valid=0, halted=0; OUT R0 (0xE0) -> out_data=0x00.
- LDI R0 (0xA0, 0x05); LDI R1 (0xA8, 0x03); ADD R0,R1 (0x02) -> alu_a=0x05, alu_b=0x03, alu_opcode=000; wb_valid with wb_addr=0, wb_data=0x08 exactly 2 cycles after ADD accept.
- SUB R0,#0x09 (0x21, 0x09) with R0=0x08 -> wb_data=0xFF (wrap); with SEQ_FLAGS_EN: flag_n=1, flag_z=0. Then AND R0,#0x00 (0x41, 0x00) -> flag_z=1.
- NOT R1 (0x88) with R1=0x03 -> R1=0xFC; then OUT R1 (0xE2) with out_ready low 5 cycles -> out_valid held, out_data=0xFC stable, instr_ready=0; out_ready=1 -> single transfer, then back to FETCH.
- HALT (0xC0) -> halted=1, instr_ready=0 while instr_valid=1 for 10 cycles, no wb_valid; reset -> FETCH.
- Reset asserted during EXEC of ADD R2,R3 -> no wb_valid; R2 reads REG_INIT via subsequent OUT.
